// File: rtl/display_scan_ctrl.sv
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed scan controller for a 7-segment display bank
//               with guard blanking, zero suppression and frame-latched values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int PRESCALE    = 50000,
  parameter int BLANK_GUARD = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] valor,
  input  logic                  supr_zeros,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [3:0]            codigo_BCD,
  output logic                  apaga,
  output logic [N_DIGITS-1:0]   anodo,
  output logic                  pendente,
  output logic                  quadro_fim
);

  localparam int c_CNT_W = $clog2(PRESCALE);
  localparam int c_IDX_W = $clog2(N_DIGITS);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(PRESCALE - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD   = c_CNT_W'(BLANK_GUARD);
  localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(N_DIGITS - 1);

  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_idx;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [4*N_DIGITS-1:0] r_active;
  logic                  r_pend;
  logic                  r_supr;
  logic [N_DIGITS-1:0]   r_mask;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_guard;
  logic                  w_off;
  logic                  w_blank;
  logic [3:0]            w_nib [N_DIGITS];
  logic [N_DIGITS-1:0]   w_hi_zero;
  logic [N_DIGITS-1:0]   w_anodo;

  // w_hi_zero[i]: digit i and everything above it hold zero
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    assign w_nib[g]     = r_active[4*g +: 4];
    assign w_hi_zero[g] = ~|r_active[4*N_DIGITS-1:4*g];
  end

  assign w_slot_end  = (r_cnt == c_CNT_MAX);
  assign w_frame_end = w_slot_end && (r_idx == c_IDX_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
      r_supr   <= 1'b0;
      r_mask   <= '0;
    end else begin
      r_supr <= supr_zeros;
      r_mask <= blank_mask;
      r_cnt  <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
      end
      // The active value only moves on the frame boundary; a load landing
      // exactly there bypasses the shadow stage.
      if (w_frame_end) begin
        if (load) begin
          r_shadow <= valor;
          r_active <= valor;
        end else if (r_pend) begin
          r_active <= r_shadow;
        end
        r_pend <= 1'b0;
      end else if (load) begin
        r_shadow <= valor;
        r_pend   <= 1'b1;
      end
    end
  end

  assign w_guard = (r_cnt < c_GUARD);
  assign w_off   = r_mask[r_idx] ||
                   (r_supr && (r_idx != '0) && w_hi_zero[r_idx]);
  assign w_blank = w_guard || w_off;

  always_comb begin
    w_anodo = '1;
    if (!w_blank) begin
      w_anodo[r_idx] = 1'b0;
    end
  end

  assign codigo_BCD = w_nib[r_idx];
  assign apaga      = w_blank;
  assign anodo      = w_anodo;
  assign pendente   = r_pend;
  assign quadro_fim = w_frame_end;

endmodule

`default_nettype wire
